// File: rtl/mac_accum.sv
// Streaming signed multiply-accumulate: one biased, saturated sum per operand vector.
// Product register (stage 1) feeds a wrapping accumulator (stage 2); results are held until accepted.
module mac_accum #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 40,
  parameter int OUT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [OUT_W-1:0] bias,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_a,
  input  logic signed [IN_W-1:0]  in_b,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat,
  output logic [15:0]             out_count
);

  typedef enum logic [1:0] {IDLE, ACC, FLUSH, OUT} state_t;

  state_t                    state_q, state_d;
  logic signed [2*IN_W-1:0]  prod_p1_q;
  logic                      vld_p1_q, last_p1_q;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [15:0]               cnt_q, cnt_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]   out_data_q, out_data_d;
  logic                      out_sat_q, out_sat_d;
  logic [15:0]               out_count_q, out_count_d;
  logic                      accept;

  // Clamp to the OUT_W range; returns {saturated, value}.
  function automatic logic [OUT_W:0] sat_acc(input logic signed [ACC_W-1:0] a);
    logic [ACC_W-OUT_W:0]    top;
    logic signed [OUT_W-1:0] v;
    logic                    s;
    top = a[ACC_W-1:OUT_W-1];
    s   = !((&top) || !(|top));
    v   = a[OUT_W-1:0];
    if (s) v = a[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    return {s, v};
  endfunction

  assign in_ready = rst_n && (state_q == IDLE || state_q == ACC);
  assign accept   = in_valid && in_ready;

  // Stage 1: operand product
  always_ff @(posedge clk) begin
    if (accept) prod_p1_q <= in_a * in_b;
  end

  // Stage 2: accumulate, sequence vector, present result
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_count_d = out_count_q;
    if (vld_p1_q) acc_d = acc_q + ACC_W'(prod_p1_q);
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = ACC_W'(bias);
          cnt_d   = 16'd1;
          state_d = in_last ? FLUSH : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          if (in_last) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (vld_p1_q && last_p1_q) state_d = OUT;
      end
      OUT: begin
        if (!out_valid_q) begin
          {out_sat_d, out_data_d} = sat_acc(acc_q);
          out_count_d = cnt_q;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      vld_p1_q    <= 1'b0;
      last_p1_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      vld_p1_q    <= accept;
      last_p1_q   <= accept && in_last;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_mac_accum.sv
// Bench for mac_accum: directed vectors with literal expectations plus a vector-level
// model (bias + sum of products, clamped) checked against the outputs every cycle.
module tb_mac_accum;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [31:0] bias = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [7:0]  in_a = '0;
  logic signed [7:0]  in_b = '0;
  logic               in_last = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [31:0] out_data;
  logic               out_sat;
  logic [15:0]        out_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mac_accum #(.IN_W(8), .ACC_W(40), .OUT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .out_count(out_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // ---------------- vector-level model ----------------
  typedef struct {
    longint data;
    bit     sat;
    longint cnt;
    int     due;
  } res_t;

  res_t   q[$];
  bit     busy = 0;
  bit     active = 0;
  longint m_sum = 0;
  longint m_cnt = 0;
  bit     exp_ov;
  res_t   r;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  // Every negedge: compare current outputs, then account for what the coming edge does.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      exp_ov = (q.size() > 0) && (cyc >= q[0].due);
      chk("model_out_valid", longint'(out_valid), longint'(exp_ov));
      chk("model_in_ready", longint'(in_ready), longint'(rst_n && !busy));
      if (exp_ov && out_valid) begin
        chk("model_out_data", longint'(out_data), q[0].data);
        chk("model_out_sat", longint'(out_sat), longint'(q[0].sat));
        chk("model_out_count", longint'(out_count), q[0].cnt);
      end
      if (!rst_n) begin
        q.delete();
        busy   = 0;
        active = 0;
      end else begin
        if (out_valid && out_ready && exp_ov) begin
          void'(q.pop_front());
          busy = 0;
        end
        if (in_valid && in_ready) begin
          if (!active) begin
            m_sum  = longint'(bias);
            m_cnt  = 0;
            active = 1;
          end
          m_sum = m_sum + longint'(in_a) * longint'(in_b);
          m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
          if (in_last) begin
            r.sat  = (m_sum > MAXV) || (m_sum < MINV);
            r.data = (m_sum > MAXV) ? MAXV : (m_sum < MINV) ? MINV : m_sum;
            r.cnt  = m_cnt;
            r.due  = cyc + 3;
            q.push_back(r);
            busy   = 1;
            active = 0;
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic beat(input int bs, input int a, input int b, input bit last);
    int n;
    n = 0;
    bias = bs; in_a = 8'(a); in_b = 8'(b); in_last = last; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("beat_accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_result(input string nm, input longint ed, input bit es,
                             input longint ec, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    chk({nm, "_valid"}, longint'(out_valid), 1);
    chk({nm, "_data"}, longint'(out_data), ed);
    chk({nm, "_sat"}, longint'(out_sat), longint'(es));
    chk({nm, "_count"}, longint'(out_count), ec);
  endtask

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_out_count", longint'(out_count), 0);
    chk("rst_in_ready", longint'(in_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: basic vector, latency of two edges after the last beat
    beat(10, 3, 4, 0);
    beat(999, -2, 5, 0);
    beat(-777, 7, 7, 1);
    wait_result("t1", 61, 0, 3, lat);
    chk("t1_latency", lat, 3);
    @(posedge clk); #1;

    // 2: bubbles between beats
    beat(10, 3, 4, 0);
    idle(2);
    beat(55, -2, 5, 0);
    idle(3);
    beat(0, 7, 7, 1);
    wait_result("t2", 61, 0, 3, lat);
    @(posedge clk); #1;

    // 3: backpressure holds the result and blocks input
    out_ready = 1'b0;
    beat(-5, 10, -3, 0);
    beat(0, 4, 4, 1);
    wait_result("t3", -19, 0, 2, lat);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      chk("t3_hold_data", longint'(out_data), -19);
      chk("t3_hold_valid", longint'(out_valid), 1);
      chk("t3_hold_in_ready", longint'(in_ready), 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t3_after_valid", longint'(out_valid), 0);
    chk("t3_after_in_ready", longint'(in_ready), 1);
    @(posedge clk); #1;

    // 4: positive and negative saturation
    beat(32'sh7FFFFF00, 127, 127, 1);
    wait_result("t4p", 64'sd2147483647, 1, 1, lat);
    @(posedge clk); #1;
    beat(32'sh80000000, -128, 127, 1);
    wait_result("t4n", -64'sd2147483648, 1, 1, lat);
    @(posedge clk); #1;

    // 5: single beat, most negative operands
    beat(0, -128, -128, 1);
    wait_result("t5", 16384, 0, 1, lat);
    @(posedge clk); #1;

    // 6: reset mid-vector discards partial sum
    beat(0, 5, 5, 0);
    beat(0, 6, 6, 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_valid", longint'(out_valid), 0);
    chk("t6_rst_data", longint'(out_data), 0);
    chk("t6_rst_sat", longint'(out_sat), 0);
    chk("t6_rst_count", longint'(out_count), 0);
    chk("t6_rst_in_ready", longint'(in_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    beat(0, 2, 3, 1);
    wait_result("t6", 6, 0, 1, lat);
    @(posedge clk); #1;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=%0d required=<finish>", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
